// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm chime controller: state encoding, default
// parameter values and a small width helper.
package alarm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUALIFY  = 3'd1,
    BEEP_ON  = 3'd2,
    BEEP_OFF = 3'd3,
    MUTED    = 3'd4
  } state_t;

  localparam int DEF_SYNC_CYCLES     = 4;
  localparam int DEF_BEEP_ON_CYCLES  = 8;
  localparam int DEF_BEEP_OFF_CYCLES = 8;
  localparam int DEF_MAX_BEEPS       = 6;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alarm_chime_ctrl_if.sv
// Alarm/Ack inputs and chime status outputs between the warning logic and the
// chime controller.
interface alarm_chime_ctrl_if
  import alarm_pkg::*;
#(
  parameter int MAX_BEEPS = DEF_MAX_BEEPS
);
  localparam int BW = $clog2(MAX_BEEPS + 1);

  logic          Alarm;
  logic          Ack;
  logic          Buzzer;
  logic          Active;
  logic          Muted;
  logic [BW-1:0] BeepCount;

  modport master (
    output Alarm, Ack,
    input  Buzzer, Active, Muted, BeepCount
  );

  modport slave (
    input  Alarm, Ack,
    output Buzzer, Active, Muted, BeepCount
  );
endinterface

// File: rtl/alarm_chime_ctrl_cycle_timer.sv
// Loadable down-counter: i_start loads i_load, o_done pulses for one cycle
// once the count has run down to zero (i_load+1 cycles after the start edge).
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_load,
  output logic         o_done
);

  logic [W-1:0] r_cnt;
  logic         r_run;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_cnt <= i_load;
      r_run <= 1'b1;
    end else if (r_run) begin
      // Stop at zero so the count never wraps and done fires only once.
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = r_run && (r_cnt == '0);

endmodule

// File: rtl/alarm_chime_ctrl.sv
// Qualifies the raw Alarm level and drives a bounded on/off Buzzer chime,
// mutable by Ack; stays silent after mute/timeout until Alarm clears.
module alarm_chime_ctrl
  import alarm_pkg::*;
#(
  parameter int SYNC_CYCLES     = DEF_SYNC_CYCLES,
  parameter int BEEP_ON_CYCLES  = DEF_BEEP_ON_CYCLES,
  parameter int BEEP_OFF_CYCLES = DEF_BEEP_OFF_CYCLES,
  parameter int MAX_BEEPS       = DEF_MAX_BEEPS
) (
  input logic               Clk,
  input logic               Rst_n,
  alarm_chime_ctrl_if.slave chime
);

  localparam int TW = $clog2(max3(BEEP_ON_CYCLES, BEEP_OFF_CYCLES, SYNC_CYCLES) + 1);
  localparam int BW = $clog2(MAX_BEEPS + 1);

  // Timer loads are one less than the phase length; QUALIFY is entered with
  // one qualifying edge already counted, hence SYNC_CYCLES-2.
  localparam logic [TW-1:0] QUAL_LOAD = TW'(SYNC_CYCLES - 2);
  localparam logic [TW-1:0] ON_LOAD   = TW'(BEEP_ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD  = TW'(BEEP_OFF_CYCLES - 1);
  localparam logic [BW-1:0] BEEP_MAX  = BW'(MAX_BEEPS);

  state_t        r_state;
  state_t        w_next;
  logic [BW-1:0] r_beeps;
  logic [BW-1:0] w_beeps_next;
  logic          r_buzzer;
  logic          r_active;
  logic          r_muted;
  logic          w_tmr_start;
  logic [TW-1:0] w_tmr_load;
  logic          w_tmr_done;

  cycle_timer #(
    .W (TW)
  ) u_timer (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_start (w_tmr_start),
    .i_load  (w_tmr_load),
    .o_done  (w_tmr_done)
  );

  always_comb begin
    w_next       = r_state;
    w_beeps_next = r_beeps;
    w_tmr_start  = 1'b0;
    w_tmr_load   = '0;
    unique case (r_state)
      IDLE: begin
        if (chime.Alarm) begin
          w_next      = QUALIFY;
          w_tmr_start = 1'b1;
          w_tmr_load  = QUAL_LOAD;
        end
      end
      QUALIFY: begin
        if (!chime.Alarm) begin
          w_next = IDLE;
        end else if (w_tmr_done) begin
          w_next      = BEEP_ON;
          w_tmr_start = 1'b1;
          w_tmr_load  = ON_LOAD;
        end
      end
      BEEP_ON: begin
        if (!chime.Alarm) begin
          w_next = IDLE;
        end else if (chime.Ack) begin
          w_next = MUTED;
        end else if (w_tmr_done) begin
          w_next      = BEEP_OFF;
          w_tmr_start = 1'b1;
          w_tmr_load  = OFF_LOAD;
          if (r_beeps != BEEP_MAX) w_beeps_next = r_beeps + 1'b1;
        end
      end
      BEEP_OFF: begin
        if (!chime.Alarm) begin
          w_next = IDLE;
        end else if (chime.Ack) begin
          w_next = MUTED;
        end else if (w_tmr_done) begin
          if (r_beeps == BEEP_MAX) begin
            w_next = MUTED;
          end else begin
            w_next      = BEEP_ON;
            w_tmr_start = 1'b1;
            w_tmr_load  = ON_LOAD;
          end
        end
      end
      MUTED: begin
        if (!chime.Alarm) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_next == IDLE) w_beeps_next = '0;
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state  <= IDLE;
      r_beeps  <= '0;
      r_buzzer <= 1'b0;
      r_active <= 1'b0;
      r_muted  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_beeps  <= w_beeps_next;
      r_buzzer <= (w_next == BEEP_ON);
      r_active <= (w_next == BEEP_ON) || (w_next == BEEP_OFF);
      r_muted  <= (w_next == MUTED);
    end
  end

  assign chime.Buzzer    = r_buzzer;
  assign chime.Active    = r_active;
  assign chime.Muted     = r_muted;
  assign chime.BeepCount = r_beeps;

endmodule

// File: tb/tb_alarm_chime_ctrl.sv
// Directed bench for alarm_chime_ctrl at default parameters: a vector table for
// reset/glitch behaviour plus hand-written multi-cycle sequences.
module tb_alarm_chime_ctrl;
  import alarm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  alarm_chime_ctrl_if #(.MAX_BEEPS(DEF_MAX_BEEPS)) bus ();

  alarm_chime_ctrl #(
    .SYNC_CYCLES     (DEF_SYNC_CYCLES),
    .BEEP_ON_CYCLES  (DEF_BEEP_ON_CYCLES),
    .BEEP_OFF_CYCLES (DEF_BEEP_OFF_CYCLES),
    .MAX_BEEPS       (DEF_MAX_BEEPS)
  ) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .chime (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       alarm;
    logic       ack;
    logic       buz;
    logic       act;
    logic       mut;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic b, input logic a,
                     input logic m, input logic [2:0] c);
    logic [5:0] got, exp;
    got = {bus.Buzzer, bus.Active, bus.Muted, bus.BeepCount};
    exp = {b, a, m, c};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got buz/act/mut/cnt=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
               name, got[5], got[4], got[3], got[2:0], b, a, m, c);
    end
  endtask

  function automatic void add(input logic r, input logic al, input logic k,
                              input logic b, input logic a, input logic m,
                              input logic [2:0] c);
    vec_t v;
    v.rst_n = r; v.alarm = al; v.ack = k;
    v.buz = b; v.act = a; v.mut = m; v.cnt = c;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; bus.Alarm = 1'b0; bus.Ack = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Alarm high for the three edges that do not yet reach the chime.
  task automatic qualify(input string name);
    bus.Alarm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk(name, 1'b0, 1'b0, 1'b0, 3'd0);
    end
  endtask

  // Runs n complete beeps starting from the edge that enters the first BEEP_ON.
  task automatic run_beeps(input string name, input int n);
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 8; i++) begin
        step();
        chk(name, 1'b1, 1'b1, 1'b0, 3'(b));
      end
      for (int i = 0; i < 8; i++) begin
        step();
        chk(name, 1'b0, 1'b1, 1'b0, 3'(b + 1));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.Alarm = 1'b0; bus.Ack = 1'b0;

    // Reset held with Alarm high, release, chime on edge 4, first beep.
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 1, 0, 1, 1, 0, 0);
    add(1, 1, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0);
    // Two 3-edge glitches are rejected.
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0);
    end
    add(1, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n     = vecs[i].rst_n;
      bus.Alarm = vecs[i].alarm;
      bus.Ack   = vecs[i].ack;
      step();
      chk($sformatf("vec%0d", i), vecs[i].buz, vecs[i].act, vecs[i].mut, vecs[i].cnt);
    end

    // Full timeout: six beeps, then muted for the rest of 200 clocks.
    do_reset();
    qualify("timeout_qual");
    run_beeps("timeout_beep", 6);
    step();
    chk("timeout_muted", 1'b0, 1'b0, 1'b1, 3'd6);
    for (int i = 0; i < 99; i++) begin
      step();
      chk("timeout_hold", 1'b0, 1'b0, 1'b1, 3'd6);
    end
    bus.Alarm = 1'b0;
    step();
    chk("timeout_clear", 1'b0, 1'b0, 1'b0, 3'd0);

    // Ack in the 3rd clock of beep 2.
    do_reset();
    qualify("ack_qual");
    run_beeps("ack_beep1", 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("ack_beep2", 1'b1, 1'b1, 1'b0, 3'd1);
    end
    bus.Ack = 1'b1;
    step();
    chk("ack_mute", 1'b0, 1'b0, 1'b1, 3'd1);
    bus.Ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("ack_hold", 1'b0, 1'b0, 1'b1, 3'd1);
    end
    bus.Alarm = 1'b0;
    step();
    chk("ack_clear", 1'b0, 1'b0, 1'b0, 3'd0);

    // Alarm drops in the off phase of beep 3, then a fresh qualification.
    do_reset();
    qualify("drop_qual");
    run_beeps("drop_beeps", 2);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("drop_beep3_on", 1'b1, 1'b1, 1'b0, 3'd2);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      chk("drop_beep3_off", 1'b0, 1'b1, 1'b0, 3'd3);
    end
    bus.Alarm = 1'b0;
    step();
    chk("drop_idle", 1'b0, 1'b0, 1'b0, 3'd0);
    qualify("drop_requal");
    step();
    chk("drop_rechime", 1'b1, 1'b1, 1'b0, 3'd0);

    // Reset mid-BEEP_ON with Ack and Alarm high; Ack ignored while qualifying.
    do_reset();
    qualify("rst_qual");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_on", 1'b1, 1'b1, 1'b0, 3'd0);
    end
    rst_n = 1'b0; bus.Ack = 1'b1;
    step();
    chk("rst_mid", 1'b0, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;
    qualify("rst_requal_ack");
    bus.Ack = 1'b0;
    step();
    chk("rst_rechime", 1'b1, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("rst_rebeep", 1'b1, 1'b1, 1'b0, 3'd0);
    end
    step();
    chk("rst_reoff", 1'b0, 1'b1, 1'b0, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_chime_ctrl.md
# alarm_chime_ctrl

Downstream consumer of the car-warning combinational alarm: takes the raw `Alarm` level, qualifies it against glitches, and drives a pulsed `Buzzer` chime. The chime is a bounded number of on/off beeps. The driver can mute it with `Ack`. Once muted or timed out, the chime stays silent until `Alarm` clears. The block sits between the warning logic and the buzzer driver pad.

## Interface
- `SYNC_CYCLES`, default 4: number of consecutive sampled `Alarm`=1 edges required before chiming; must be ≥2.
- `BEEP_ON_CYCLES`, default 8: `Buzzer` high time per beep, in clocks; must be ≥1.
- `BEEP_OFF_CYCLES`, default 8: `Buzzer` low time between beeps, in clocks; must be ≥1.
- `MAX_BEEPS`, default 6: number of beeps before automatic timeout; must be ≥1.
- `Clk`  in  1  sole clock, rising edge.
- `Rst_n`  in  1  reset, synchronous and active-low.
- `Alarm`  in  1  raw warning level from the car-warning logic.
- `Ack`  in  1  driver mute request, level-sampled.
- `Buzzer`  out  1  chime drive.
- `Active`  out  1  high while beeping (on or off phase).
- `Muted`  out  1  high while silenced by `Ack` or timeout with `Alarm` still asserted.
- `BeepCount`  out  $clog2(MAX_BEEPS+1)  number of completed beeps in the current episode.

## Operation
- Moore FSM with states IDLE, QUALIFY, BEEP_ON, BEEP_OFF, MUTED.
- All outputs are registered and decoded from the state and counter registers.
- Reset values:
  - state = IDLE.
  - `Buzzer`, `Active`, `Muted` = 0.
  - `BeepCount` = 0.
  - timer = 0.
- **IDLE:**
  - `Alarm`=1 → QUALIFY, with qual count = 1.
  - `BeepCount` is cleared whenever the FSM is in or enters IDLE.
- **QUALIFY:**
  - `Alarm`=0 → IDLE.
  - Otherwise increment qual count.
  - The edge that would make the count equal to `SYNC_CYCLES` → BEEP_ON, with timer loaded.
  - `Ack` is ignored in this state.
- **BEEP_ON:**
  - `Buzzer`=1, `Active`=1.
  - After exactly `BEEP_ON_CYCLES` cycles in this state → BEEP_OFF, and `BeepCount` increments on that edge.
- **BEEP_OFF:**
  - `Buzzer`=0, `Active`=1.
  - After `BEEP_OFF_CYCLES` cycles: if `BeepCount`==`MAX_BEEPS` → MUTED, else → BEEP_ON.
- **MUTED:**
  - `Muted`=1, `Buzzer`=0.
  - `BeepCount` is held.
  - `Alarm`=0 → IDLE.
- Priority on every edge, in BEEP_ON and BEEP_OFF:
  - `Rst_n`=0 wins over everything.
  - Next, `Alarm`=0 → IDLE.
  - Next, `Ack`=1 → MUTED.
  - Last, the timer-driven transitions above.
- An `Ack` received in BEEP_ON does not count the partial beep; `BeepCount` is unchanged.
- Counters saturate and never wrap. The timer width is `$clog2(max(BEEP_ON_CYCLES, BEEP_OFF_CYCLES, SYNC_CYCLES)+1)`.

## Timing
- Chime latency:
  - Label the first edge that samples `Alarm`=1 from IDLE as edge 1.
  - `Buzzer` rises on edge `SYNC_CYCLES`, i.e. 4 with defaults.
- Beep timing:
  - Each beep drives `Buzzer` high for exactly `BEEP_ON_CYCLES` clocks and low for `BEEP_OFF_CYCLES` clocks.
  - The period is 16 clocks with defaults.
- Muting:
  - After timeout, `Muted` rises on the edge ending the last off phase.
  - After `Ack`, `Buzzer` falls and `Muted` rises on the edge that samples `Ack`=1.
- Clearing: `Alarm`=0 sampled in any non-IDLE state clears all outputs on that edge.
- Reset mid-operation forces reset values on the edge sampling `Rst_n`=0, regardless of state.
- `Alarm` and `Ack` are synchronous to `Clk`; synchronizers are the upstream stage's responsibility.

## Structure
- Shared package `alarm_pkg` holds:
  - the state encoding (3-bit localparams or enum: IDLE=0, QUALIFY=1, BEEP_ON=2, BEEP_OFF=3, MUTED=4);
  - the default parameter values, for reuse by the top-level and the bench.
- One sub-module, `cycle_timer`:
  - a loadable down-counter with a `load` value, a `start` input and a `done` pulse;
  - shared by the QUALIFY, BEEP_ON and BEEP_OFF phases.
- The FSM and `BeepCount` live in `alarm_chime_ctrl`.

## Test plan
1. **Reset and release.** Hold `Rst_n`=0 for 2 clocks with `Alarm`=1 → all outputs 0. After release, `Buzzer` rises on the 4th edge.
2. **Glitch rejection.** `Alarm` high for 3 edges, then low → `Buzzer` never rises and the FSM returns to IDLE. A second 3-edge glitch does the same.
3. **Full timeout.** Hold `Alarm` high for 200 clocks:
   - six 8-high/8-low pulses occur, with `Active`=1 throughout;
   - then `Muted`=1 with `BeepCount`=6 and `Buzzer`=0;
   - drop `Alarm` → all outputs 0 on the next edge.
4. **Ack mid-beep.** Assert `Ack` in the 3rd clock of beep 2 → `Buzzer`=0 and `Muted`=1 on that edge, and `BeepCount` stays 1.
5. **Alarm drops during BEEP_OFF of beep 3.** → IDLE and `BeepCount`=0 on the next edge. Re-raising `Alarm` requires a fresh 4-edge qualification.
6. **Reset mid-BEEP_ON, with `Ack`=1 and `Alarm`=1 asserted simultaneously.** → reset values on that edge. After release, normal qualification and chime restart.
